simple_writeback: RTL and testbench
===================================

# simple_writeback

Write-back stage of the SIMPLE 16-bit pipeline, directly downstream of the memory stage. Takes the memory stage's registered load data, the ALU result carried alongside it, and the destination-register control. Selects the write-back value and commits it to the 8×16 general register file. Serves the decode stage's two register read ports and keeps a retired-instruction count plus a halt state.

## Interface
- `DATA_W`, 16, datapath width
- `NUM_REGS`, 8, general registers; address width is log2(`NUM_REGS`) = 3
- `clock` input 1: single clock, rising edge
- `reset_n` input 1: asynchronous, active-low reset
- `in_valid` input 1: memory-stage output holds a real instruction this cycle
- `mem_data` input 16: load data from memory stage (`readOutData`)
- `alu_data` input 16: ALU result, aligned with `mem_data`
- `wb_sel` input 1: 1 = write `mem_data`, 0 = write `alu_data`
- `write_reg` input 1: instruction writes a register (`WriteReg`)
- `reg_address` input 3: destination register (`RegAddress`)
- `halt` input 1: instruction is HLT
- `rd_addr1`, `rd_addr2` input 3: decode-stage read addresses
- `rd_data1`, `rd_data2` output 16: combinational read data
- `wb_we` output 1: registered copy of the committed write enable (for upstream forwarding)
- `wb_addr` output 3: registered committed address
- `wb_data` output 16: registered committed data
- `retired` output 16: count of retired instructions
- `halted` output 1: stage is in HALTED

## Operation
- Commit condition: `commit = in_valid & write_reg & (state == RUN)`.
- Write value is `wb_sel ? mem_data : alu_data`, 16 bits, no extension.
- On `commit`, regs[`reg_address`] takes the write value at the rising edge.
- Every `in_valid` cycle in RUN increments `retired`, including HLT and non-writing instructions. The counter saturates at 0xFFFF and does not wrap.
- FSM states:
  - RUN → HALTED on `in_valid & halt`.
  - A HLT that also has `write_reg` set still commits its write, and is counted.
  - HALTED is terminal until reset.
  - In HALTED: no register writes, `retired` frozen, `wb_we` = 0, inputs ignored.
- `wb_we`/`wb_addr`/`wb_data` register `commit`, `reg_address`, and the write value each cycle. `wb_addr`/`wb_data` hold their last values when `commit` = 0.
- Read ports return regs[`rd_addrN`] combinationally. See Configuration for same-cycle write bypass.
- Two reads of the same address are legal. No write port conflict is possible because there is one write port.

## Timing
- Write latency: value is visible in the array one edge after the commit cycle.
- `wb_*` outputs are valid the cycle after commit.
- `retired`/`halted` update at the edge ending the qualifying cycle.
- Reset (asynchronous assert, any time including mid-write) forces:
  - all regs = 0x0000
  - `retired` = 0
  - state = RUN, `halted` = 0
  - `wb_we` = 0, `wb_addr` = 0, `wb_data` = 0x0000
- A write coincident with reset assertion is lost.
- `rd_data*` during reset read 0x0000, except bypass.

## Configuration
- `SIMPLE_WB_BYPASS_EN` defined:
  - If `commit` and `rd_addrN == reg_address`, `rd_dataN` returns the write value in the same cycle (write-before-read).
  - The decode stage then needs no extra stall for a write-back hazard.
- Undefined:
  - `rd_dataN` returns the old array contents during the commit cycle.
  - The new value is visible from the next cycle.
- No other behaviour differs.

## Structure
- `simple_pkg`: `DATA_W`, `NUM_REGS`, `REG_AW`, `wb_sel` encodings (`WB_ALU = 1'b0`, `WB_MEM = 1'b1`), FSM state type (`ST_RUN`, `ST_HALTED`).
- Sub-module `simple_regfile`:
  - one write port, two asynchronous read ports, asynchronous reset
  - bypass logic lives inside it under the same macro
- Top level holds the mux, FSM, counter and `wb_*` registers.

## Test plan
- Reset, then read all 8 registers via both ports → all 0x0000; `retired` = 0, `halted` = 0.
- `in_valid=1, write_reg=1, wb_sel=1, mem_data=0xBEEF, reg_address=5` → next cycle `rd_data1` (addr 5) = 0xBEEF; `wb_we=1, wb_addr=5, wb_data=0xBEEF`; `retired` = 1.
- Same cycle as a commit of 0x1234 to r3 (`wb_sel=0, alu_data=0x1234`), read `rd_addr2=3`:
  - with `SIMPLE_WB_BYPASS_EN`, the same cycle → 0x1234
  - without it, the same cycle → old value 0x0000; the next cycle → 0x1234
- `in_valid=1, halt=1, write_reg=1`, r2 ← 0x00AA, then a write r2 ← 0x5555 → r2 stays 0x00AA; `halted=1`; `retired` frozen; `wb_we=0`.
- Preload `retired` to 0xFFFE via 2 + 65532 valid cycles, then 3 more → saturates at 0xFFFF.
- Assert `reset_n=0` mid-stream between edges with regs loaded → all outputs zero immediately (asynchronous); after release, normal commits resume.

Source files
------------

// File: rtl/simple_pkg.sv
// rtl/simple_pkg.sv - shared widths, write-back select encodings and FSM state type
package simple_pkg;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int REG_AW   = $clog2(NUM_REGS);

  localparam logic WB_ALU = 1'b0;
  localparam logic WB_MEM = 1'b1;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wb_state_t;
endpackage

// File: rtl/simple_writeback_if.sv
// rtl/simple_writeback_if.sv - memory-stage input, decode read ports and forwarding outputs
interface simple_writeback_if;
  import simple_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] alu_data;
  logic              wb_sel;
  logic              write_reg;
  logic [REG_AW-1:0] reg_address;
  logic              halt;
  logic [REG_AW-1:0] rd_addr1;
  logic [REG_AW-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              wb_we;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] retired;
  logic              halted;

  modport master (
    output in_valid, mem_data, alu_data, wb_sel, write_reg, reg_address, halt,
    output rd_addr1, rd_addr2,
    input  rd_data1, rd_data2, wb_we, wb_addr, wb_data, retired, halted
  );

  modport slave (
    input  in_valid, mem_data, alu_data, wb_sel, write_reg, reg_address, halt,
    input  rd_addr1, rd_addr2,
    output rd_data1, rd_data2, wb_we, wb_addr, wb_data, retired, halted
  );
endinterface

// File: rtl/simple_regfile.sv
// rtl/simple_regfile.sv - 8x16 register file, one write port, two async read ports
// SIMPLE_WB_BYPASS_EN enables same-cycle write-before-read on the read ports.
module simple_regfile
  import simple_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

`ifdef SIMPLE_WB_BYPASS_EN
  // Bypass lets decode see a write-back result without a hazard stall.
  assign rdata1 = (we && (raddr1 == waddr)) ? wdata : regs[raddr1];
  assign rdata2 = (we && (raddr2 == waddr)) ? wdata : regs[raddr2];
`else
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];
`endif
endmodule

// File: rtl/simple_writeback.sv
// rtl/simple_writeback.sv - write-back stage: result mux, halt FSM, retire counter, wb_* registers
// SIMPLE_WB_BYPASS_EN is consumed by simple_regfile.
module simple_writeback
  import simple_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  simple_writeback_if.slave  bus
);
  wb_state_t         state;
  wb_state_t         state_nxt;
  logic              commit;
  logic              run_valid;
  logic [DATA_W-1:0] wr_value;

  assign wr_value = (bus.wb_sel == WB_MEM) ? bus.mem_data : bus.alu_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_RUN && bus.in_valid && bus.halt) state_nxt = ST_HALTED;
  end

  always_comb begin
    run_valid  = bus.in_valid && (state == ST_RUN);
    commit     = run_valid && bus.write_reg;
    bus.halted = (state == ST_HALTED);
  end

  // Retire count saturates rather than wrapping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.retired <= '0;
    end else if (run_valid && (bus.retired != {DATA_W{1'b1}})) begin
      bus.retired <= bus.retired + DATA_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.wb_we   <= 1'b0;
      bus.wb_addr <= '0;
      bus.wb_data <= '0;
    end else begin
      bus.wb_we <= commit;
      if (commit) begin
        bus.wb_addr <= bus.reg_address;
        bus.wb_data <= wr_value;
      end
    end
  end

  simple_regfile u_regfile (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (commit),
    .waddr   (bus.reg_address),
    .wdata   (wr_value),
    .raddr1  (bus.rd_addr1),
    .raddr2  (bus.rd_addr2),
    .rdata1  (bus.rd_data1),
    .rdata2  (bus.rd_data2)
  );
endmodule

// File: tb/tb_simple_writeback.sv
// tb/tb_simple_writeback.sv - self-checking bench for simple_writeback
module tb_simple_writeback;
  import simple_pkg::*;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  bit   run_cmp = 1'b0;

  always #5 clock = ~clock;

  simple_writeback_if bus ();

  simple_writeback dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: register array, retire count, halt flag, last commit.
  logic [15:0] m_regs [8];
  logic [15:0] m_retired = '0;
  bit          m_halted  = 1'b0;
  bit          m_we      = 1'b0;
  logic [2:0]  m_addr    = '0;
  logic [15:0] m_data    = '0;

  initial for (int i = 0; i < 8; i++) m_regs[i] = '0;

  function automatic logic [15:0] wval();
    return bus.wb_sel ? bus.mem_data : bus.alu_data;
  endfunction

  function automatic logic [15:0] exp_rd(input logic [2:0] a);
`ifdef SIMPLE_WB_BYPASS_EN
    if (bus.in_valid && bus.write_reg && !m_halted && a == bus.reg_address) return wval();
`endif
    return m_regs[a];
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_retired = '0;
      m_halted  = 1'b0;
      m_we      = 1'b0;
      m_addr    = '0;
      m_data    = '0;
    end else if (!m_halted && bus.in_valid) begin
      m_we = bus.write_reg;
      if (bus.write_reg) begin
        m_regs[bus.reg_address] = wval();
        m_addr = bus.reg_address;
        m_data = wval();
      end
      if (m_retired < 16'hFFFF) m_retired = m_retired + 16'd1;
      if (bus.halt) m_halted = 1'b1;
    end else begin
      m_we = 1'b0;
    end
  end

  always @(negedge clock) begin
    if (run_cmp) begin
      chk("cmp_rd_data1", bus.rd_data1, exp_rd(bus.rd_addr1));
      chk("cmp_rd_data2", bus.rd_data2, exp_rd(bus.rd_addr2));
      chk("cmp_wb_we",    bus.wb_we,    m_we);
      chk("cmp_wb_addr",  bus.wb_addr,  m_addr);
      chk("cmp_wb_data",  bus.wb_data,  m_data);
      chk("cmp_retired",  bus.retired,  m_retired);
      chk("cmp_halted",   bus.halted,   m_halted);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic instr(input logic v, input logic wr, input logic sel, input logic [15:0] mem,
                       input logic [15:0] alu, input logic [2:0] addr, input logic h);
    bus.in_valid    = v;
    bus.write_reg   = wr;
    bus.wb_sel      = sel;
    bus.mem_data    = mem;
    bus.alu_data    = alu;
    bus.reg_address = addr;
    bus.halt        = h;
  endtask

  task automatic idle();
    instr(1'b0, 1'b0, WB_ALU, 16'h0, 16'h0, 3'd0, 1'b0);
  endtask

  initial begin
    idle();
    bus.rd_addr1 = '0;
    bus.rd_addr2 = '0;
    #1 run_cmp = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      bus.rd_addr1 = 3'(i);
      bus.rd_addr2 = 3'(7 - i);
      #1;
      chk("reset_rd1", bus.rd_data1, 16'h0000);
      chk("reset_rd2", bus.rd_data2, 16'h0000);
    end
    chk("reset_retired", bus.retired, 16'd0);
    chk("reset_halted",  bus.halted,  1'b0);
    chk("reset_wb_we",   bus.wb_we,   1'b0);

    // Load path into r5
    step();
    bus.rd_addr1 = 3'd5;
    instr(1'b1, 1'b1, WB_MEM, 16'hBEEF, 16'h1111, 3'd5, 1'b0);
    step();
    idle();
    #1;
    chk("beef_rd1",     bus.rd_data1, 16'hBEEF);
    chk("beef_wb_we",   bus.wb_we,    1'b1);
    chk("beef_wb_addr", bus.wb_addr,  3'd5);
    chk("beef_wb_data", bus.wb_data,  16'hBEEF);
    chk("beef_retired", bus.retired,  16'd1);

    // Same-cycle read of the register being written
    step();
    bus.rd_addr2 = 3'd3;
    instr(1'b1, 1'b1, WB_ALU, 16'hDEAD, 16'h1234, 3'd3, 1'b0);
    #1;
`ifdef SIMPLE_WB_BYPASS_EN
    chk("byp_same_cycle", bus.rd_data2, 16'h1234);
`else
    chk("byp_same_cycle", bus.rd_data2, 16'h0000);
`endif
    step();
    idle();
    #1;
    chk("byp_next_cycle", bus.rd_data2, 16'h1234);
    chk("byp_retired",    bus.retired,  16'd2);

    instr(1'b1, 1'b1, WB_MEM, 16'h0001, 16'h9999, 3'd0, 1'b0);
    step();
    instr(1'b1, 1'b1, WB_ALU, 16'h0F0F, 16'hFFFF, 3'd7, 1'b0);
    step();
    bus.rd_addr1 = 3'd0;
    bus.rd_addr2 = 3'd7;
    instr(1'b1, 1'b0, WB_ALU, 16'h0000, 16'h7777, 3'd1, 1'b0);
    step();
    chk("nowr_wb_we",   bus.wb_we,   1'b0);
    chk("nowr_wb_data", bus.wb_data, 16'hFFFF);
    instr(1'b0, 1'b1, WB_ALU, 16'h0000, 16'h3333, 3'd1, 1'b0);
    step();
    idle();
    #1;
    chk("r0_value",      bus.rd_data1, 16'h0001);
    chk("r7_value",      bus.rd_data2, 16'hFFFF);
    chk("invalid_noret", bus.retired,  16'd5);
    bus.rd_addr1 = 3'd1;
    #1 chk("r1_untouched", bus.rd_data1, 16'h0000);

    // HLT with a write, then a write that must be ignored
    bus.rd_addr1 = 3'd2;
    instr(1'b1, 1'b1, WB_ALU, 16'h0000, 16'h00AA, 3'd2, 1'b1);
    step();
    instr(1'b1, 1'b1, WB_MEM, 16'h5555, 16'h0000, 3'd2, 1'b0);
    step();
    idle();
    #1;
    chk("halt_r2",      bus.rd_data1, 16'h00AA);
    chk("halt_halted",  bus.halted,   1'b1);
    chk("halt_retired", bus.retired,  16'd6);
    chk("halt_wb_we",   bus.wb_we,    1'b0);
    chk("halt_wb_data", bus.wb_data,  16'h00AA);

    // Asynchronous reset between edges, write in flight is lost
    instr(1'b1, 1'b1, WB_ALU, 16'h0000, 16'h6666, 3'd6, 1'b0);
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("areset_rd1",     bus.rd_data1, 16'h0000);
    chk("areset_retired", bus.retired,  16'd0);
    chk("areset_halted",  bus.halted,   1'b0);
    chk("areset_wb_we",   bus.wb_we,    1'b0);
    chk("areset_wb_addr", bus.wb_addr,  3'd0);
    chk("areset_wb_data", bus.wb_data,  16'h0000);
    step();
    reset_n = 1'b1;
    idle();
    bus.rd_addr1 = 3'd6;
    #1 chk("lost_write_r6", bus.rd_data1, 16'h0000);
    bus.rd_addr1 = 3'd4;
    instr(1'b1, 1'b1, WB_ALU, 16'h0000, 16'h4444, 3'd4, 1'b0);
    step();
    idle();
    #1;
    chk("resume_r4",      bus.rd_data1, 16'h4444);
    chk("resume_retired", bus.retired,  16'd1);

    // Saturation of the retire counter
    step();
    #2 reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      instr(1'b1, i[0], WB_ALU, 16'h0000, i[15:0], i[2:0], 1'b0);
      step();
    end
    idle();
    #1 chk("sat_fffe", bus.retired, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      instr(1'b1, 1'b0, WB_ALU, 16'h0000, 16'h0000, 3'd0, 1'b0);
      step();
    end
    idle();
    #1 chk("sat_ffff", bus.retired, 16'hFFFF);
    step();
    step();

    run_cmp = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
